// File: rtl/demux_pkg.sv
// Shared constants and types for the registered 1-to-2 demultiplexer.
// Holds the default data width and the output slot state encoding.
package demux_pkg;

    localparam int DEMUX_WIDTH = 8;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

`ifdef DEMUX_COUNT_EN
    localparam bit DEMUX_HAS_CNT = 1'b1;
`else
    localparam bit DEMUX_HAS_CNT = 1'b0;
`endif

endpackage

// File: rtl/demux_out_slot.sv
// One-entry holding register with valid/ready on the output side.
// Ports: clk, rst (sync, active-high); wr_en/wr_data load a beat;
// out_ready drains it; can_accept = slot empty or draining this cycle;
// out_valid/out_data present the held beat (data retained when empty).
module demux_out_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             out_ready,
    output logic             can_accept,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    slot_state_t      state_q;
    slot_state_t      state_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    assign can_accept = (state_q == SLOT_EMPTY) || out_ready;
    assign out_valid  = (state_q == SLOT_FULL);
    assign out_data   = data_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        // A write wins over a drain: simultaneous in/out keeps it FULL.
        if (wr_en) begin
            state_d = SLOT_FULL;
            data_d  = wr_data;
        end else if (state_q == SLOT_FULL && out_ready) begin
            state_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/demux_1to2_reg.sv
// Registered 1-to-2 demultiplexer: in_sel steers each beat to one of
// two one-entry output slots, which drain independently.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_sel/in_data;
// outN_valid/outN_ready/outN_data per channel; with DEMUX_COUNT_EN
// defined, cnt0/cnt1 count accepted beats per channel (wrapping).
module demux_1to2_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
`ifdef DEMUX_COUNT_EN
    output logic [WIDTH-1:0] cnt0,
    output logic [WIDTH-1:0] cnt1,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data
);

    logic acc0;
    logic acc1;
    logic wr0;
    logic wr1;

    // Ready follows the selected slot; held low in reset so nothing
    // presented during reset is ever accepted.
    assign in_ready = !rst && (in_sel ? acc1 : acc0);
    assign wr0      = in_valid && in_ready && !in_sel;
    assign wr1      = in_valid && in_ready && in_sel;

    demux_out_slot #(
        .WIDTH(WIDTH)
    ) u_slot0 (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr0),
        .wr_data   (in_data),
        .out_ready (out0_ready),
        .can_accept(acc0),
        .out_valid (out0_valid),
        .out_data  (out0_data)
    );

    demux_out_slot #(
        .WIDTH(WIDTH)
    ) u_slot1 (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr1),
        .wr_data   (in_data),
        .out_ready (out1_ready),
        .can_accept(acc1),
        .out_valid (out1_valid),
        .out_data  (out1_data)
    );

`ifdef DEMUX_COUNT_EN
    logic [WIDTH-1:0] cnt0_q;
    logic [WIDTH-1:0] cnt0_d;
    logic [WIDTH-1:0] cnt1_q;
    logic [WIDTH-1:0] cnt1_d;

    always_comb begin
        cnt0_d = cnt0_q + {{(WIDTH-1){1'b0}}, wr0};
        cnt1_d = cnt1_q + {{(WIDTH-1){1'b0}}, wr1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_demux_1to2_reg.sv
// Self-checking bench for demux_1to2_reg: directed vector table,
// randomized model-driven traffic, and a per-channel order scoreboard.
module tb_demux_1to2_reg;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       in_sel;
    logic [7:0] in_data;
    logic       out0_valid;
    logic       out0_ready;
    logic [7:0] out0_data;
    logic       out1_valid;
    logic       out1_ready;
    logic [7:0] out1_data;
`ifdef DEMUX_COUNT_EN
    logic [7:0] cnt0;
    logic [7:0] cnt1;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    // reference model state
    logic       mv0 = 1'b0;
    logic       mv1 = 1'b0;
    logic [7:0] md0 = 8'h00;
    logic [7:0] md1 = 8'h00;
    logic [7:0] mc0 = 8'h00;
    logic [7:0] mc1 = 8'h00;

    typedef struct {
        logic       rst;
        logic       iv;
        logic       is;
        logic [7:0] id;
        logic       r0;
        logic       r1;
        logic       rdy;
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
    } vec_t;

    vec_t tbl[14];

    demux_1to2_reg #(
        .WIDTH(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef DEMUX_COUNT_EN
        .cnt0      (cnt0),
        .cnt1      (cnt1),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out0_valid(out0_valid),
        .out0_ready(out0_ready),
        .out0_data (out0_data),
        .out1_valid(out1_valid),
        .out1_ready(out1_ready),
        .out1_data (out1_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_pop(input int ch, input logic [7:0] act);
        logic [7:0] e;
        if (ch == 0 && q0.size() == 0 || ch == 1 && q1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_extra%0d: got %0h expected none", ch, act);
        end else begin
            e = (ch == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("sb_order%0d", ch), 32'(act), 32'(e));
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        rst        = v.rst;
        in_valid   = v.iv;
        in_sel     = v.is;
        in_data    = v.id;
        out0_ready = v.r0;
        out1_ready = v.r1;
        #1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(v.rdy));
        if (!v.rst && out0_valid && out0_ready) sb_pop(0, out0_data);
        if (!v.rst && out1_valid && out1_ready) sb_pop(1, out1_data);
        if (v.rst) begin
            q0.delete();
            q1.delete();
        end else if (v.iv && v.rdy) begin
            if (v.is) q1.push_back(v.id);
            else q0.push_back(v.id);
        end
        @(posedge clk);
        #1;
        chk({tag, ".v0"}, 32'(out0_valid), 32'(v.v0));
        chk({tag, ".d0"}, 32'(out0_data), 32'(v.d0));
        chk({tag, ".v1"}, 32'(out1_valid), 32'(v.v1));
        chk({tag, ".d1"}, 32'(out1_data), 32'(v.d1));
    endtask

    // Expected values from the reference model, then advance it.
    task automatic step_model(input logic r, input logic iv,
                              input logic is, input logic [7:0] id,
                              input logic r0, input logic r1,
                              input string tag);
        vec_t v;
        logic a0;
        logic a1;
        v.rst = r;
        v.iv  = iv;
        v.is  = is;
        v.id  = id;
        v.r0  = r0;
        v.r1  = r1;
        v.rdy = !r && (is ? (!mv1 || r1) : (!mv0 || r0));
        a0 = iv && v.rdy && !is;
        a1 = iv && v.rdy && is;
        if (r) begin
            mv0 = 1'b0; md0 = 8'h00; mc0 = 8'h00;
            mv1 = 1'b0; md1 = 8'h00; mc1 = 8'h00;
        end else begin
            if (a0) begin
                mv0 = 1'b1; md0 = id; mc0 = mc0 + 8'd1;
            end else if (mv0 && r0) mv0 = 1'b0;
            if (a1) begin
                mv1 = 1'b1; md1 = id; mc1 = mc1 + 8'd1;
            end else if (mv1 && r1) mv1 = 1'b0;
        end
        v.v0 = mv0;
        v.d0 = md0;
        v.v1 = mv1;
        v.d1 = md1;
        apply(v, tag);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = 8'h00;
        out0_ready = 1'b0; out1_ready = 1'b0;

        //        rst   iv    is    id     r0    r1    rdy   v0    d0     v1    d1
        tbl[0]  = '{1'b1,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,8'h00};
        tbl[1]  = '{1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b1,1'b0,8'h00,1'b0,8'h00};
        tbl[2]  = '{1'b0,1'b0,1'b1,8'h00,1'b0,1'b0,1'b1,1'b0,8'h00,1'b0,8'h00};
        tbl[3]  = '{1'b0,1'b1,1'b0,8'hA5,1'b0,1'b0,1'b1,1'b1,8'hA5,1'b0,8'h00};
        tbl[4]  = '{1'b0,1'b1,1'b0,8'h5A,1'b0,1'b0,1'b0,1'b1,8'hA5,1'b0,8'h00};
        tbl[5]  = '{1'b0,1'b1,1'b1,8'h3C,1'b0,1'b1,1'b1,1'b1,8'hA5,1'b1,8'h3C};
        tbl[6]  = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,1'b1,1'b0,8'hA5,1'b1,8'h3C};
        tbl[7]  = '{1'b0,1'b1,1'b0,8'h11,1'b0,1'b0,1'b1,1'b1,8'h11,1'b1,8'h3C};
        tbl[8]  = '{1'b0,1'b1,1'b0,8'h22,1'b1,1'b0,1'b1,1'b1,8'h22,1'b1,8'h3C};
        tbl[9]  = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b1,1'b1,1'b0,8'h22,1'b0,8'h3C};
        tbl[10] = '{1'b0,1'b1,1'b1,8'h77,1'b0,1'b0,1'b1,1'b0,8'h22,1'b1,8'h77};
        tbl[11] = '{1'b0,1'b1,1'b0,8'h88,1'b0,1'b0,1'b1,1'b1,8'h88,1'b1,8'h77};
        tbl[12] = '{1'b1,1'b1,1'b0,8'h99,1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,8'h00};
        tbl[13] = '{1'b0,1'b0,1'b1,8'h00,1'b0,1'b0,1'b1,1'b0,8'h00,1'b0,8'h00};

        for (int i = 0; i < 14; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // randomized traffic against the model
        step_model(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "rnd_rst");
        for (int i = 0; i < 300; i++) begin
            step_model(1'b0, 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 8'($urandom()),
                       1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)),
                       $sformatf("rnd%0d", i));
        end
        step_model(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "drain0");
        step_model(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "drain1");
        chk("sb_left0", 32'(q0.size()), 32'd0);
        chk("sb_left1", 32'(q1.size()), 32'd0);

`ifdef DEMUX_COUNT_EN
        step_model(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "cnt_rst");
        chk("cnt0_rst", 32'(cnt0), 32'd0);
        chk("cnt1_rst", 32'(cnt1), 32'd0);
        for (int i = 0; i < 256; i++) begin
            step_model(1'b0, 1'b1, 1'b1, 8'(i), 1'b0, 1'b1,
                       $sformatf("cnt%0d", i));
            if (i == 254) chk("cnt1_255", 32'(cnt1), 32'(mc1));
        end
        chk("cnt1_wrap", 32'(cnt1), 32'd0);
        chk("cnt0_zero", 32'(cnt0), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_1to2_reg.md
DEMUX_1TO2_REG -- requirements
Module: demux_1to2_reg

Interface
REQ-001 Parameter: WIDTH, 8, data width of input and both output channels.
REQ-002 Port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: in_valid  input  1  upstream presents a beat.
REQ-005 Port: in_ready  output  1  block accepts the presented beat this cycle.
REQ-006 Port: in_sel  input  1  destination of the beat: 0 = channel 0, 1 = channel 1.
REQ-007 Port: in_data  input  WIDTH  beat payload.
REQ-008 Port: out0_valid / out1_valid  output  1  channel holds a beat.
REQ-009 Port: out0_ready / out1_ready  input  1  downstream takes the held beat this cycle.
REQ-010 Port: out0_data / out1_data  output  WIDTH  held payload per channel.
REQ-011 Port (DEMUX_COUNT_EN only): cnt0 / cnt1  output  WIDTH  accepted-beat count per channel.

Function
REQ-012 Each channel SHALL be a one-entry slot with states EMPTY (outN_valid=0) and FULL (outN_valid=1).
REQ-013 Transfer in: in_valid && in_ready at a rising edge; transfer out: outN_valid && outN_ready.
REQ-014 in_ready SHALL be combinational: slot selected by in_sel is EMPTY, or FULL with its outN_ready=1; in_ready SHALL be 0 while rst=1.
REQ-015 in_sel and in_data SHALL only be used when in_valid=1.
REQ-016 Latency: an accepted beat SHALL appear on the selected channel's outputs in the cycle after acceptance.
REQ-017 EMPTY -> FULL on transfer in to that slot; FULL -> EMPTY on transfer out with no transfer in; FULL stays FULL, data replaced, on simultaneous transfer out and in (one beat per cycle per channel).
REQ-018 While FULL and outN_ready=0, outN_data and outN_valid SHALL hold stable.
REQ-019 The non-selected channel SHALL be unaffected by a transfer in; both channels drain independently in the same cycle.
REQ-020 outN_data SHALL retain its last value when EMPTY.
REQ-021 Beats per channel SHALL leave in acceptance order; no beat is dropped or duplicated.

Reset
REQ-022 With rst=1 at a rising edge: out0_valid=out1_valid=0, out0_data=out1_data=0, counters=0.
REQ-023 Reset mid-operation SHALL discard held beats; a beat presented in a reset cycle SHALL not be accepted.

Configuration
REQ-024 Macro DEMUX_COUNT_EN defined: cnt0/cnt1 present, each increments by 1 per transfer in to its channel, wraps 2^WIDTH-1 -> 0.
REQ-025 DEMUX_COUNT_EN undefined: cnt0/cnt1 ports and counter logic absent; all other behaviour identical.

Structure
REQ-026 Shared package demux_pkg SHALL hold the default WIDTH constant (8) and the slot-state enum (SLOT_EMPTY, SLOT_FULL).
REQ-027 One sub-module demux_out_slot (one-entry holding register with valid/ready) SHALL be instantiated once per channel.

Verification
REQ-028 Reset then idle: out0_valid=out1_valid=0, out*_data=0, in_ready=1 for either in_sel.
REQ-029 in_sel=0, in_data=8'hA5, out0_ready=0 -> next cycle out0_valid=1, out0_data=8'hA5; next beat to ch0 sees in_ready=0; out1_valid stays 0.
REQ-030 ch0 FULL with 8'h11, out0_ready=1, new beat 8'h22 to ch0 same cycle -> in_ready=1, next cycle out0_valid=1, out0_data=8'h22.
REQ-031 ch0 stalled FULL, beat 8'h3C to ch1 with out1_ready=1 -> accepted, out1_data=8'h3C next cycle, out0_data unchanged.
REQ-032 rst asserted while both channels FULL and in_valid=1 -> next cycle both valids 0, in_ready=0 during reset, beat not delivered.
REQ-033 DEMUX_COUNT_EN: 256 beats to ch1 from reset -> cnt1 wraps to 0, cnt0=0; build without macro compiles with no cnt ports.
